stsystem_rx: RTL and testbench
==============================

# stsystem_rx

Serial receiver for the Serial Transmission System: the receiving end of the 11-bit frame (start, 8 data bits MSB first, parity, stop) that the shift-register transmitter drives on `TX`. It oversamples the line, finds the start edge, samples each bit at mid-bit and checks parity and stop. It presents the byte in parallel with a ready/acknowledge handshake, plus error and overrun flags for the host logic.

## Interface
- `OVS`, 8: rxclk cycles per bit; even, ≥4; transmitter bit clock = rxclk/OVS.
- `PARITY_ODD`, 1: 1 = odd parity over d[7:0] plus parity bit; 0 = even.
- `rxclk` input 1: receive clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rx` input 1: serial line, asynchronous to `rxclk`; idles high.
- `ack` input 1: host has consumed `q`; clears `rdy`.
- `q` output 8: last received byte, d[7] = first data bit on the line.
- `rdy` output 1: `q` holds an unconsumed byte.
- `valid` output 1: one-cycle pulse per completed frame, including frames with errors.
- `par_err` output 1: parity mismatch on the last frame.
- `frm_err` output 1: stop bit sampled 0 on the last frame.
- `overrun` output 1: a frame completed while `rdy`=1; sticky until `ack`.
- `busy` output 1: state ≠ IDLE.
- `extra_frame` output [0:10]: debug copy of the last received frame in line order: [0]=start, [1..8]=d7..d0, [9]=parity, [10]=stop.

## Operation
- Line format: start = 0, stop = 1, idle = 1.
- `rx` passes through a 2-FF synchronizer. Every reference to "line" below means the synchronized value.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: when the line is 0, go to START and set the sample counter to 0.
  - START: at counter = OVS/2−1, re-check the line. If 0, go to DATA with the counter at 0. If 1, treat it as a false start and return to IDLE with no flags changed.
  - DATA/PARITY/STOP: sample at counter = OVS−1, which is mid-bit, then reset the counter. DATA shifts 8 bits in MSB first, with the bit counter counting 0..7. Then PARITY takes one sample, then STOP takes one sample.
  - At the stop sample:
    - Load `q` and `extra_frame`.
    - Set `par_err` = (XOR of the 8 data bits and the parity bit) ≠ `PARITY_ODD`.
    - Set `frm_err` = !stop.
    - Pulse `valid`.
    - Set `overrun` if `rdy` was already 1.
    - Set `rdy`.
    - Next state is IDLE if stop = 1, otherwise WAIT_HIGH.
  - WAIT_HIGH: stay until the line is 1, then go to IDLE. This prevents a break or stuck-low line from retriggering.
- `q`, `par_err`, `frm_err` and `extra_frame` are loaded even when there is an error, and hold until the next completed frame.
- `ack` handshake:
  - `ack`=1 clears `rdy` and `overrun` on the next edge.
  - If `ack` coincides with the frame-completion edge, completion wins: `rdy`=1, and `overrun` is set from the pre-edge `rdy`.
- `ack` with `rdy`=0 has no effect.

## Timing
- Reset values: `q`=0, `rdy`=0, `valid`=0, `par_err`=0, `frm_err`=0, `overrun`=0, `busy`=0, `extra_frame`=all 1. The state goes to IDLE and both counters to 0. Synchronizer flops reset to 1.
- Reset asserted mid-frame aborts immediately. No `valid` pulse is produced for the aborted frame.
- Synchronizer latency is 2 rxclk cycles.
- Let edge E be the rxclk edge where IDLE sees line = 0. Relative to E:
  - The start check occurs at E+OVS/2.
  - Data bit k (0 = d7) is sampled at E+OVS/2+(k+1)·OVS.
  - Parity is sampled at E+OVS/2+9·OVS.
  - Stop is sampled at E+OVS/2+10·OVS.
- `valid`, `rdy` and the flags are registered at the stop-sample edge and visible in the following cycle.
- Back-to-back frames: IDLE may accept a new start on the edge immediately after the stop sample. No dead time is required beyond that.
- Tolerated bit-rate mismatch is about ±4%, from mid-bit sampling over 10.5 bit times.

## Structure
- `stsystem_pkg` contains:
  - The state enum.
  - `DATA_BITS`=8.
  - `FRAME_BITS`=11.
  - Line-level constants `START_BIT`=0 and `STOP_BIT`=1.
- Sub-module `stsystem_sync2`: a 2-flop synchronizer with asynchronous active-high reset to a reset-value parameter, instantiated once for `rx`.
- The sample counter is $clog2(OVS) bits wide. The bit counter is 3 bits.

## Test plan
- Odd parity, OVS=8. Send 0xA5 with parity 1 and stop 1 → `q`=0xA5, `valid` pulse exactly once at E+85, `par_err`=0, `frm_err`=0, `rdy`=1, `extra_frame`=0_10100101_1_1.
- Send 0x3C with a wrong parity bit → `q`=0x3C, `par_err`=1, `valid` pulses. Then send a good frame → `par_err`=0.
- Stop bit forced 0, then line held low for 30 cycles → `frm_err`=1, `busy` stays 1 (WAIT_HIGH). There is no second `valid` until the line returns high and a new start arrives.
- Glitch: line low for 2 cycles, then high → no `valid`, `busy` returns to 0 within OVS/2+1 cycles, all flags unchanged.
- Two frames (0x01, 0xFF) sent back-to-back with no `ack` → `q`=0xFF and `overrun`=1. An `ack` on the same edge as the second completion still yields `overrun`=1 and `rdy`=1. A later `ack` clears both.
- Loopback from the transmitter at txclk = rxclk/8 for 256 random bytes, with `rst` pulsed mid-frame once → every post-reset byte matches with no errors. The aborted frame produces no `valid`, and outputs return to their reset values.

Source files
------------

// File: rtl/stsystem_pkg.sv
// Shared types and constants for the serial transmission system receiver.
// Holds the receive FSM state encoding, frame geometry and line levels.
// Also provides the parity-error helper used at the stop-bit sample.
package stsystem_pkg;

  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = 11;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  // A frame is bad when the ones-count parity of data+parity differs from
  // the configured sense (1 = odd, 0 = even).
  function automatic logic calc_par_err(input logic [DATA_BITS-1:0] d,
                                        input logic                 p,
                                        input logic                 odd);
    return ((^d) ^ p) != odd;
  endfunction

endpackage

// File: rtl/stsystem_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Latency: 2 clk cycles from d to q.
// Reset drives both stages to RST_VAL so the output is defined immediately.
module stsystem_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Each stage simply copies the stage in front of it.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Capture chain; the first stage may go metastable, the second resolves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/stsystem_rx.sv
// Oversampling UART-style receiver: start, 8 data MSB first, parity, stop.
// Latency: valid/rdy/flags appear one cycle after the mid-stop-bit sample.
// No backpressure: a frame completing while rdy=1 is kept and flags overrun.
module stsystem_rx
  import stsystem_pkg::*;
#(
  parameter int OVS        = 8,
  parameter bit PARITY_ODD = 1'b1
) (
  input  logic                  rxclk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  ack,
  output logic [DATA_BITS-1:0]  q,
  output logic                  rdy,
  output logic                  valid,
  output logic                  par_err,
  output logic                  frm_err,
  output logic                  overrun,
  output logic                  busy,
  output logic [0:FRAME_BITS-1] extra_frame
);

  localparam int             CW       = $clog2(OVS);
  localparam logic [CW-1:0]  CNT_HALF = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(OVS - 1);
  localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

  logic line;

  rx_state_e              state_q,   state_d;
  logic [CW-1:0]          cnt_q,     cnt_d;
  logic [2:0]             bit_q,     bit_d;
  logic [DATA_BITS-1:0]   shift_q,   shift_d;
  logic                   par_bit_q, par_bit_d;
  logic [DATA_BITS-1:0]   q_q,       q_d;
  logic                   rdy_q,     rdy_d;
  logic                   valid_q,   valid_d;
  logic                   par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d;
  logic                   overrun_q, overrun_d;
  logic [0:FRAME_BITS-1]  ef_q,      ef_d;

  // The serial line idles high, so the synchronizer resets to 1 to avoid a
  // phantom start edge coming out of reset.
  stsystem_sync2 #(
    .RST_VAL (STOP_BIT)
  ) u_sync_rx (
    .clk (rxclk),
    .rst (rst),
    .d   (rx),
    .q   (line)
  );

  // Frame FSM: counts oversample ticks, samples mid-bit, completes at stop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    q_d       = q_q;
    rdy_d     = rdy_q;
    valid_d   = 1'b0;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    overrun_d = overrun_q;
    ef_d      = ef_q;

    // Host consumption; a frame completing on the same edge overrides this.
    if (ack) begin
      rdy_d     = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (line == START_BIT) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (line == START_BIT) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            // Too short to be a start bit: drop it without touching flags.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {shift_q[DATA_BITS-2:0], line};
          if (bit_q == BIT_LAST) begin
            state_d = PARITY;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d     = '0;
          par_bit_d = line;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d     = '0;
          q_d       = shift_q;
          ef_d      = {START_BIT, shift_q, par_bit_q, line};
          par_err_d = calc_par_err(shift_q, par_bit_q, PARITY_ODD);
          frm_err_d = (line != STOP_BIT);
          valid_d   = 1'b1;
          // Overrun reflects the pre-edge rdy, even if ack arrives now.
          overrun_d = rdy_q;
          rdy_d     = 1'b1;
          // A low stop bit means a break or stuck line; wait for it to clear.
          state_d   = (line == STOP_BIT) ? IDLE : WAIT_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_HIGH: begin
        if (line == STOP_BIT) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      q_q       <= '0;
      rdy_q     <= 1'b0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      overrun_q <= 1'b0;
      ef_q      <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      q_q       <= q_d;
      rdy_q     <= rdy_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      overrun_q <= overrun_d;
      ef_q      <= ef_d;
    end
  end

  assign q           = q_q;
  assign rdy         = rdy_q;
  assign valid       = valid_q;
  assign par_err     = par_err_q;
  assign frm_err     = frm_err_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != IDLE);
  assign extra_frame = ef_q;

endmodule

// File: tb/tb_stsystem_rx.sv
// Scoreboard bench for stsystem_rx: a line driver emits whole frames and
// queues the expected result; a monitor checks each valid pulse against it.
// Directed checks cover reset, glitch, break, overrun and mid-frame reset.
module tb_stsystem_rx;

  localparam int OVS  = 8;
  localparam bit PODD = 1'b1;
  // Cycles from driving the start bit to the cycle in which valid is seen:
  // 3 (sync + IDLE detect) + half bit + 10 full bits.
  localparam int VLAT = 3 + OVS / 2 + 10 * OVS;

  logic        rxclk = 1'b0;
  logic        rst;
  logic        rx;
  logic        ack;
  logic [7:0]  q;
  logic        rdy, valid, par_err, frm_err, overrun, busy;
  logic [0:10] extra_frame;

  stsystem_rx #(.OVS(OVS), .PARITY_ODD(PODD)) dut (
    .rxclk       (rxclk),
    .rst         (rst),
    .rx          (rx),
    .ack         (ack),
    .q           (q),
    .rdy         (rdy),
    .valid       (valid),
    .par_err     (par_err),
    .frm_err     (frm_err),
    .overrun     (overrun),
    .busy        (busy),
    .extra_frame (extra_frame)
  );

  always #5 rxclk = ~rxclk;

  int unsigned cyc = 0;
  always @(posedge rxclk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  q;
    logic        pe;
    logic        fe;
    logic        ovr;
    logic [0:10] ef;
    int unsigned vcyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   valid_seen  = 0;
  bit   model_pending = 1'b0;  // host has not yet acknowledged a byte
  bit   model_ovr     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_q"},       32'(q),           32'h0);
    check({tag, "_rdy"},     32'(rdy),         32'h0);
    check({tag, "_valid"},   32'(valid),       32'h0);
    check({tag, "_par_err"}, 32'(par_err),     32'h0);
    check({tag, "_frm_err"}, 32'(frm_err),     32'h0);
    check({tag, "_overrun"}, 32'(overrun),     32'h0);
    check({tag, "_busy"},    32'(busy),        32'h0);
    check({tag, "_extra"},   32'(extra_frame), 32'h7FF);
  endtask

  function automatic logic good_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    // Choose p so that total ones over data+parity has the configured sense.
    return ((ones % 2) == 1) ? ~PODD : PODD;
  endfunction

  // Drive one full frame on the line; must be called right after a negedge.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    exp_t        e;
    logic [10:0] bits;
    int          ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    e.q   = d;
    e.pe  = (((ones + int'(p)) % 2) == 1) != PODD;
    e.fe  = ~s;
    e.ovr = model_pending | model_ovr;
    e.ef[0] = 1'b0;
    for (int k = 0; k < 8; k++) e.ef[1 + k] = d[7 - k];
    e.ef[9]  = p;
    e.ef[10] = s;
    e.vcyc = cyc + VLAT;
    sb.push_back(e);
    model_ovr     = e.ovr;
    model_pending = 1'b1;
    bits = {1'b0, d, p, s};
    for (int i = 10; i >= 0; i--) begin
      rx = bits[i];
      repeat (OVS) @(negedge rxclk);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge rxclk);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge rxclk);
    ack = 1'b0;
    model_pending = 1'b0;
    model_ovr     = 1'b0;
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge rxclk) begin
    if (!rst && valid) begin
      valid_seen++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: got valid=1 expected no frame (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("valid_cycle", 32'(cyc),         32'(mon_e.vcyc));
        check("q",           32'(q),           32'(mon_e.q));
        check("par_err",     32'(par_err),     32'(mon_e.pe));
        check("frm_err",     32'(frm_err),     32'(mon_e.fe));
        check("overrun",     32'(overrun),     32'(mon_e.ovr));
        check("extra_frame", 32'(extra_frame), 32'(mon_e.ef));
        check("rdy_on_valid", 32'(rdy),        32'h1);
      end
    end
  end

  initial begin
    int          vs;
    int unsigned c0;
    logic [7:0]  b;

    rst = 1'b1;
    rx  = 1'b1;
    ack = 1'b0;
    repeat (3) @(negedge rxclk);
    check_reset("reset");
    rst = 1'b0;
    idle(4);

    // Known frame with correct odd parity.
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(2);
    check("a5_q",   32'(q),   32'hA5);
    check("a5_rdy", 32'(rdy), 32'h1);
    check("a5_count", 32'(valid_seen), 32'd1);

    // Wrong parity, then a good frame clears par_err.
    send_frame(8'h3C, ~good_par(8'h3C), 1'b1);
    idle(3);
    send_frame(8'h5A, good_par(8'h5A), 1'b1);
    idle(2);
    check("par_recover", 32'(par_err), 32'h0);
    do_ack();
    check("ack_clears_rdy", 32'(rdy), 32'h0);
    check("ack_clears_ovr", 32'(overrun), 32'h0);

    // Stop bit low followed by a held-low line: no retrigger.
    vs = valid_seen;
    send_frame(8'h96, good_par(8'h96), 1'b0);
    rx = 1'b0;
    repeat (30) @(negedge rxclk);
    check("break_busy",    32'(busy),       32'h1);
    check("break_frm_err", 32'(frm_err),    32'h1);
    check("break_count",   32'(valid_seen), 32'(vs + 1));
    idle(12);
    check("break_released", 32'(busy), 32'h0);
    send_frame(8'h42, good_par(8'h42), 1'b1);
    idle(2);
    do_ack();

    // Two-cycle glitch must look like a false start.
    vs = valid_seen;
    rx = 1'b0;
    repeat (2) @(negedge rxclk);
    rx = 1'b1;
    repeat (2) @(negedge rxclk);
    check("glitch_seen",  32'(busy), 32'h1);
    repeat (4) @(negedge rxclk);
    check("glitch_idle",  32'(busy), 32'h0);
    idle(4);
    check("glitch_count", 32'(valid_seen), 32'(vs));
    check("glitch_q",     32'(q),          32'h42);
    check("glitch_pe",    32'(par_err),    32'h0);
    check("glitch_fe",    32'(frm_err),    32'h0);
    check("glitch_rdy",   32'(rdy),        32'h0);

    // Back-to-back frames; ack lands on the second completion edge.
    send_frame(8'h01, good_par(8'h01), 1'b1);
    c0 = cyc;
    fork
      send_frame(8'hFF, good_par(8'hFF), 1'b1);
      begin
        repeat (VLAT - 1) @(negedge rxclk);
        ack = 1'b1;
        @(negedge rxclk);
        ack = 1'b0;
      end
    join
    idle(2);
    check("b2b_q",       32'(q),       32'hFF);
    check("b2b_overrun", 32'(overrun), 32'h1);
    check("b2b_rdy",     32'(rdy),     32'h1);
    check("b2b_elapsed", 32'(cyc - c0 >= VLAT), 32'h1);
    do_ack();
    check("late_ack_rdy", 32'(rdy),     32'h0);
    check("late_ack_ovr", 32'(overrun), 32'h0);
    do_ack();
    check("idle_ack_rdy", 32'(rdy), 32'h0);
    check("idle_ack_q",   32'(q),   32'hFF);

    // Random loopback traffic with one frame aborted by reset.
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i == 100) begin
        vs = valid_seen;
        rx = 1'b0;
        repeat (OVS) @(negedge rxclk);
        for (int k = 7; k >= 4; k--) begin
          rx = b[k];
          repeat (OVS) @(negedge rxclk);
        end
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge rxclk);
        check_reset("abort");
        rst = 1'b0;
        model_pending = 1'b0;
        model_ovr     = 1'b0;
        idle(OVS * 12);
        check_reset("post_abort");
        check("abort_count", 32'(valid_seen), 32'(vs));
      end else begin
        send_frame(b, good_par(b), 1'b1);
        if ($urandom_range(0, 3) != 0) do_ack();
        idle(int'($urandom_range(0, 3)));
      end
    end

    idle(20);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
